fifo_word_packer: RTL and testbench

Downstream drain stage for the 128x8 `sync_fifo`. It pops bytes from the FIFO read port, accounts for the FIFO's one-cycle read latency, and packs bytes into 32-bit words. Words are presented on a valid/ready output port with a byte-keep mask and a last flag. A flush request forces out a partial trailing word.

---
 rtl/fifo_word_packer.sv | 193 +++++++++++++++++++
 tb/tb_fifo_word_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//
// Drain stage for a byte-wide synchronous FIFO with one-cycle read latency.
// It pops bytes, packs them little-endian into BYTES-byte words and presents
// each word on a valid/ready port. A flush request forces out a partial
// trailing word with a reduced keep mask and the last flag set.
//
// Ports
//   clk          sole clock, rising edge
//   rst_         synchronous, active-high reset
//   fifo_empty   FIFO empty flag
//   fifo_rdEn    pop request (combinational from fifo_empty, flush, rst_)
//   fifo_rdData  FIFO read data, valid the cycle after a pop
//   flush        single-cycle request to emit any partial word
//   out_valid    output word valid
//   out_ready    consumer accepts the word when high with out_valid
//   out_data     packed word, first-popped byte in the lowest lane
//   out_keep     per-lane valid mask
//   out_last     word closes a flush
//   word_count   number of accepted words, wraps
//   busy         any byte or word still held, or a flush pending
module fifo_word_packer #(
  parameter int BYTES  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    fifo_empty,
  output logic                    fifo_rdEn,
  input  logic [DATA_W-1:0]       fifo_rdData,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTES*DATA_W-1:0] out_data,
  output logic [BYTES-1:0]        out_keep,
  output logic                    out_last,
  output logic [CNT_W-1:0]        word_count,
  output logic                    busy
);

  localparam int CW  = $clog2(BYTES + 1);
  localparam int CW1 = CW + 1;

  localparam logic [CW-1:0]  FULL_CNT  = CW'(BYTES);
  localparam logic [CW-1:0]  LAST_LANE = CW'(BYTES - 1);
  localparam logic [CW1-1:0] FULL_SUM  = CW1'(BYTES);

  // FILL is normal operation. FLUSH_WAIT holds while the in-flight byte and
  // the output register drain; the edge that leaves it is the one that loads
  // the partial word (or simply clears the request when nothing is held).
  localparam logic [0:0] FILL       = 1'b0;
  localparam logic [0:0] FLUSH_WAIT = 1'b1;

  typedef logic [BYTES-1:0][DATA_W-1:0] word_t;

  function automatic logic [BYTES-1:0] keep_mask(input logic [CW-1:0] n);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (CW'(i) < n);
    return m;
  endfunction

  // Lanes beyond the keep mask are zeroed so partial words never expose
  // stale bytes left in the accumulator.
  function automatic word_t mask_word(input word_t w, input logic [BYTES-1:0] k);
    word_t r;
    for (int i = 0; i < BYTES; i++) r[i] = k[i] ? w[i] : '0;
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  word_t            acc_q, acc_d;
  logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
  logic             inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  word_t            out_data_q, out_data_d;
  logic [BYTES-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             busy_q, busy_d;

  logic             flush_pend;
  logic             out_free;
  logic             fire;
  logic [CW1-1:0]   sum;
  logic             pop;
  word_t            acc_land;

  always_comb begin
    flush_pend = (state_q == FLUSH_WAIT);
    out_free   = !out_valid_q || out_ready;
    fire       = out_valid_q && out_ready;
    sum        = CW1'(acc_cnt_q) + CW1'(inflight_q);

    // A byte may be popped while it has room; the byte that would start the
    // next word behind a completing one needs the output register empty so
    // the completed word can leave the accumulator as it lands.
    pop = !rst_ && !fifo_empty && !flush && !flush_pend &&
          ((sum < FULL_SUM) ||
           ((sum == FULL_SUM) && !out_valid_q && (acc_cnt_q < FULL_CNT)));

    acc_land = acc_q;
    for (int i = 0; i < BYTES; i++) begin
      if (acc_cnt_q == CW'(i)) acc_land[i] = fifo_rdData;
    end

    state_d      = state_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    inflight_d   = pop;
    out_valid_d  = out_valid_q && !fire;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    word_count_d = fire ? word_count_q + CNT_W'(1) : word_count_q;

    if (!flush_pend && flush) state_d = FLUSH_WAIT;

    if (inflight_q) begin
      acc_d = acc_land;
      if (acc_cnt_q == LAST_LANE) begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_land;
          out_keep_d  = '1;
          out_last_d  = 1'b0;
          acc_cnt_d   = '0;
        end else begin
          acc_cnt_d = FULL_CNT;
        end
      end else begin
        acc_cnt_d = acc_cnt_q + CW'(1);
      end
    end else if ((acc_cnt_q == FULL_CNT) && out_free) begin
      // A parked full word leaves before any flush handling, so a flush that
      // races a completing word still sees it go out with last=0.
      out_valid_d = 1'b1;
      out_data_d  = acc_q;
      out_keep_d  = '1;
      out_last_d  = 1'b0;
      acc_cnt_d   = '0;
    end else if (flush_pend && out_free) begin
      if (acc_cnt_q != '0) begin
        out_valid_d = 1'b1;
        out_keep_d  = keep_mask(acc_cnt_q);
        out_data_d  = mask_word(acc_q, keep_mask(acc_cnt_q));
        out_last_d  = 1'b1;
        acc_cnt_d   = '0;
      end
      state_d = FILL;
    end

    busy_d = (acc_cnt_d != '0) || inflight_d || out_valid_d || (state_d == FLUSH_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q      <= FILL;
      acc_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      word_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      inflight_q   <= inflight_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      word_count_q <= word_count_d;
      busy_q       <= busy_d;
    end
  end

  // Accumulator lanes carry data only; acc_cnt_q says which are meaningful.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign fifo_rdEn  = pop;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_last   = out_last_q;
  assign word_count = word_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: behavioural FIFO with one-cycle read
// latency, a byte-stream reference model that chops pushed bytes into words,
// a flush-vector table, hand-written corner sequences and randomized traffic.
module tb_fifo_word_packer;
  localparam int BYTES  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int WW     = BYTES * DATA_W;

  logic              clk = 1'b0;
  logic              rst_;
  logic              fifo_empty;
  logic              fifo_rdEn;
  logic [DATA_W-1:0] fifo_rdData = '0;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WW-1:0]     out_data;
  logic [BYTES-1:0]  out_keep;
  logic              out_last;
  logic [CNT_W-1:0]  word_count;
  logic              busy;

  always #5 clk = ~clk;

  fifo_word_packer #(.BYTES(BYTES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_(rst_), .fifo_empty(fifo_empty), .fifo_rdEn(fifo_rdEn),
    .fifo_rdData(fifo_rdData), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .word_count(word_count), .busy(busy)
  );

  // Source FIFO: written by the stimulus, read on pops with one-cycle latency.
  logic [7:0] mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       gate_empty;
  logic       fake_data;
  assign fifo_empty = gate_empty | ((wr_ptr == rd_ptr) & !fake_data);

  always @(posedge clk) begin
    if (fifo_rdEn) begin
      fifo_rdData <= mem[rd_ptr % 256];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  typedef logic [WW+BYTES:0] wrec_t;  // {data, keep, last}
  wrec_t      got[$];
  wrec_t      exp_q[$];
  logic [7:0] mq[$];
  int         exp_wc = 0;
  int         n_total = 0;
  int         n_pass = 0;

  typedef struct {
    int          n;
    logic [7:0]  base;
    logic [7:0]  step;
    int          words;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } fvec_t;
  fvec_t tbl[6];

  // Output snapshot taken mid-cycle by tick().
  logic             s_rden, s_ov, s_last, s_busy;
  logic [WW-1:0]    s_data;
  logic [BYTES-1:0] s_keep;
  logic [CNT_W-1:0] s_wc;
  logic             hold_v = 1'b0;
  logic [WW+BYTES+1:0] hold_w = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic model_emit(input logic last);
    logic [WW-1:0]    d;
    logic [BYTES-1:0] k;
    d = '0;
    k = '0;
    for (int i = 0; i < mq.size(); i++) begin
      d[8*i +: 8] = mq[i];
      k[i] = 1'b1;
    end
    exp_q.push_back({d, k, last});
    exp_wc++;
    mq.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    mq.push_back(b);
    if (mq.size() == BYTES) model_emit(1'b0);
  endtask

  task automatic model_flush();
    if (mq.size() > 0) model_emit(1'b1);
  endtask

  task automatic push(input logic [7:0] b, input bit feed);
    mem[wr_ptr % 256] = b;
    wr_ptr++;
    if (feed) model_byte(b);
  endtask

  task automatic tick();
    @(negedge clk);
    s_rden = fifo_rdEn; s_ov = out_valid; s_data = out_data; s_keep = out_keep;
    s_last = out_last; s_wc = word_count; s_busy = busy;
    if (hold_v) check("hold_stable", 64'({out_valid, out_data, out_keep, out_last}), 64'(hold_w));
    hold_v = !rst_ && out_valid && !out_ready;
    hold_w = {out_valid, out_data, out_keep, out_last};
    if (!rst_ && out_valid && out_ready) got.push_back({out_data, out_keep, out_last});
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    out_ready  = 1'b1;
    gate_empty = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_words(input string name);
    check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_word%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  logic [11:0] seq_r, seq_v;
  int          base;
  int          n;

  initial begin
    tbl[0] = '{0, 8'h00, 8'h00, 0, 32'h00000000, 4'b0000, 1'b0};
    tbl[1] = '{1, 8'h5A, 8'h01, 1, 32'h0000005A, 4'b0001, 1'b1};
    tbl[2] = '{3, 8'h11, 8'h11, 1, 32'h00332211, 4'b0111, 1'b1};
    tbl[3] = '{4, 8'h01, 8'h01, 1, 32'h04030201, 4'b1111, 1'b0};
    tbl[4] = '{6, 8'hA0, 8'h01, 2, 32'h0000A5A4, 4'b0011, 1'b1};
    tbl[5] = '{8, 8'hF8, 8'h01, 2, 32'hFFFEFDFC, 4'b1111, 1'b0};

    // Reset with a non-empty FIFO: no pops, all outputs zero.
    rst_ = 1'b1; fake_data = 1'b1; gate_empty = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    check("reset_rden_c1", 64'(s_rden), 0);
    tick();
    check("reset_outputs_c2", 64'({s_rden, s_ov, s_data, s_keep, s_last, s_wc, s_busy}), 0);
    rst_ = 1'b0; fake_data = 1'b0;
    tick();
    check("idle_after_reset", 64'({s_rden, s_ov, s_data, s_keep, s_last, s_wc, s_busy}), 0);

    // Streaming: 8 back-to-back pops, first word valid BYTES+1 cycles later.
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
    seq_r = '0; seq_v = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seq_r = {seq_r[10:0], s_rden};
      seq_v = {seq_v[10:0], s_ov};
    end
    check("stream_rden_run", 64'(seq_r), 64'(12'hFF0));
    check("stream_valid_timing", 64'(seq_v), 64'(12'h044));
    settle(5);
    check_words("stream");
    check("stream_word_count", 64'(s_wc), 64'(exp_wc));

    // Backpressure: pops stop at one held word plus a full accumulator.
    out_ready = 1'b0;
    base = rd_ptr;
    for (int i = 1; i <= 12; i++) push(8'(i), 1'b1);
    repeat (20) tick();
    check("bp_pops", 64'(rd_ptr - base), 8);
    check("bp_head", 64'({s_ov, s_data}), 64'({1'b1, 32'h04030201}));
    settle(20);
    check_words("bp");
    check("bp_word_count", 64'(s_wc), 64'(exp_wc));
    check("bp_busy_idle", 64'(s_busy), 0);

    // Flush vectors: n bytes land, then a flush pulse.
    for (int t = 0; t < 6; t++) begin
      got.delete();
      for (int i = 0; i < tbl[t].n; i++) push(tbl[t].base + 8'(i) * tbl[t].step, 1'b0);
      settle(20);
      flush = 1'b1; tick(); flush = 1'b0;
      settle(20);
      exp_wc += tbl[t].words;
      check($sformatf("tbl%0d_words", t), 64'(got.size()), 64'(tbl[t].words));
      if (got.size() > 0)
        check($sformatf("tbl%0d_last_word", t), 64'(got[got.size()-1]),
              64'({tbl[t].data, tbl[t].keep, tbl[t].last}));
      check($sformatf("tbl%0d_busy_idle", t), 64'(s_busy), 0);
      check($sformatf("tbl%0d_word_count", t), 64'(s_wc), 64'(exp_wc));
      got.delete();
    end

    // Flush in the cycle the word-completing byte lands.
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b1);
    repeat (4) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    model_flush();
    settle(20);
    check_words("flush_land");
    check("flush_land_word_count", 64'(s_wc), 64'(exp_wc));
    check("flush_land_busy_idle", 64'(s_busy), 0);

    // Reset with two bytes accumulated and a third in flight.
    for (int i = 0; i < 3; i++) push(8'hE1 + 8'(i), 1'b0);
    for (int c = 0; c < 10 && rd_ptr != wr_ptr; c++) tick();
    check("rst_mid_popped", 64'(rd_ptr == wr_ptr), 1);
    rst_ = 1'b1; tick(); rst_ = 1'b0;
    mq.delete();
    exp_wc = 0;
    settle(5);
    check("rst_mid_quiet", 64'({s_ov, s_busy, s_wc}), 0);
    check_words("rst_mid_nothing");
    for (int i = 0; i < 4; i++) push(8'hB1 + 8'(i), 1'b1);
    settle(20);
    check_words("rst_mid_clean");
    check("rst_mid_word_count", 64'(s_wc), 64'(exp_wc));

    // Randomized traffic with stalls on both sides, closed by a flush.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(20, 45);
      for (int i = 0; i < n; i++) push(8'($urandom_range(0, 255)), 1'b1);
      for (int c = 0; c < 2000 && rd_ptr != wr_ptr; c++) begin
        out_ready  = ($urandom_range(0, 99) < 60);
        gate_empty = ($urandom_range(0, 99) < 25);
        tick();
      end
      check($sformatf("rand%0d_drained", r), 64'(rd_ptr == wr_ptr), 1);
      settle(20);
      flush = 1'b1; tick(); flush = 1'b0;
      model_flush();
      settle(20);
      check_words($sformatf("rand%0d", r));
      check($sformatf("rand%0d_word_count", r), 64'(s_wc), 64'(exp_wc));
      check($sformatf("rand%0d_busy_idle", r), 64'(s_busy), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
